// File: rtl/led_pwm_driver.sv
// LED pin driver: global PWM brightness with pattern/duty shadowed at period boundaries.
// Define LED_PWM_BLINK_EN to add the blink_en input and a 16-period 50% blink.
module led_pwm_driver #(
  parameter int PRESCALE_W = 8,
  parameter int DUTY_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            led_in,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale_div,
  input  logic                  duty_wr_en,
  input  logic [DUTY_W-1:0]     duty_in,
`ifdef LED_PWM_BLINK_EN
  input  logic                  blink_en,
`endif
  output logic [7:0]            led_out,
  output logic                  period_tick
);

  localparam logic [PRESCALE_W-1:0] PS_ONE = PRESCALE_W'(1);
  localparam logic [DUTY_W-1:0]     D_ONE  = DUTY_W'(1);

  logic [PRESCALE_W-1:0] r_prescaler;
  logic [DUTY_W-1:0]     r_pwm_cnt;
  logic [DUTY_W-1:0]     r_duty_reg;
  logic [DUTY_W-1:0]     r_duty_shadow;
  logic [7:0]            r_led_shadow;
  logic [7:0]            r_led_out;
  logic                  r_period_tick;

  logic w_tick;
  logic w_over;
  logic w_wrap;
  logic w_on;
  logic w_blank;

  always_comb begin
    w_tick = (r_prescaler == prescale_div);
    w_over = (r_prescaler > prescale_div);
    w_wrap = w_tick && (r_pwm_cnt == {DUTY_W{1'b1}});
    w_on   = (r_duty_shadow == {DUTY_W{1'b1}}) ||
             (r_pwm_cnt < r_duty_shadow);
  end

`ifdef LED_PWM_BLINK_EN
  logic [3:0] r_blink_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= 4'd0;
    end else if (!enable) begin
      r_blink_cnt <= 4'd0;
    end else if (w_wrap) begin
      r_blink_cnt <= r_blink_cnt + 4'd1;
    end
  end

  assign w_blank = blink_en & r_blink_cnt[3];
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_duty_reg <= '0;
    end else if (duty_wr_en) begin
      r_duty_reg <= duty_in;
    end
  end

  // a shrunk prescale_div restarts the prescaler without a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescaler <= '0;
      r_pwm_cnt   <= '0;
    end else if (!enable) begin
      r_prescaler <= '0;
      r_pwm_cnt   <= '0;
    end else begin
      if (w_tick || w_over) begin
        r_prescaler <= '0;
      end else begin
        r_prescaler <= r_prescaler + PS_ONE;
      end
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + D_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led_shadow  <= 8'h00;
      r_duty_shadow <= '0;
    end else if (!enable || w_wrap) begin
      r_led_shadow  <= led_in;
      r_duty_shadow <= r_duty_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led_out     <= 8'h00;
      r_period_tick <= 1'b0;
    end else begin
      r_period_tick <= enable & w_wrap;
      if (enable && w_on && !w_blank) begin
        r_led_out <= r_led_shadow;
      end else begin
        r_led_out <= 8'h00;
      end
    end
  end

  assign led_out     = r_led_out;
  assign period_tick = r_period_tick;

endmodule
